// File: rtl/tdm_demux_if.sv
// Serial TDM word stream in, per-channel holding registers and strobes out.
// master drives the stream side; slave is the demultiplexer.
interface tdm_demux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    logic                 in_valid;
    logic                 in_sync;
    logic [WIDTH-1:0]     x;
    logic [NCH*WIDTH-1:0] y;
    logic [NCH-1:0]       y_valid;
    logic                 frame_done;
    logic                 sync_err;
    logic                 locked;

    modport master (
        output in_valid, in_sync, x,
        input  y, y_valid, frame_done, sync_err, locked
    );

    modport slave (
        input  in_valid, in_sync, x,
        output y, y_valid, frame_done, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes slot words to channel registers, tracks frame alignment (TDM_DEMUX_ZERO_ON_ERR_EN clears stale channels on sync errors).
// Latency: word accepted at edge n is on y with its strobe right after edge n.
// Backpressure: none, every presented word is consumed or dropped in the same cycle.
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CW    = 4
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t               state;
    logic [CW-1:0]        slot;
    logic [NCH*WIDTH-1:0] y_q;
    logic [NCH-1:0]       y_valid_q;
    logic                 frame_done_q;
    logic                 sync_err_q;
    logic                 locked_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            slot         <= '0;
            y_q          <= '0;
            y_valid_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            y_valid_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.in_sync) begin
                            y_q[WIDTH-1:0] <= bus.x;
                            y_valid_q      <= NCH'(1);
                            slot           <= CW'(1);
                            state          <= LOCKED;
                            locked_q       <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (bus.in_sync) begin
                            // Early sync restarts the frame; truncated frame gets no frame_done.
                            if (slot != '0) begin
                                sync_err_q <= 1'b1;
`ifdef TDM_DEMUX_ZERO_ON_ERR_EN
                                y_q <= {{((NCH-1)*WIDTH){1'b0}}, bus.x};
`else
                                y_q[WIDTH-1:0] <= bus.x;
`endif
                            end else begin
                                y_q[WIDTH-1:0] <= bus.x;
                            end
                            y_valid_q <= NCH'(1);
                            slot      <= CW'(1);
                        end else if (slot == '0) begin
                            sync_err_q <= 1'b1;
                            state      <= HUNT;
                            locked_q   <= 1'b0;
`ifdef TDM_DEMUX_ZERO_ON_ERR_EN
                            y_q <= '0;
`endif
                        end else begin
                            y_q[int'(slot)*WIDTH +: WIDTH] <= bus.x;
                            y_valid_q <= NCH'(1) << slot;
                            if (slot == CW'(NCH-1)) begin
                                frame_done_q <= 1'b1;
                                slot         <= '0;
                            end else begin
                                slot <= slot + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.y          = y_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = locked_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (NCH=4, WIDTH=8): directed frames with literal pins, then random traffic vs a frame model.
module tb_tdm_demux;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
`ifdef TDM_DEMUX_ZERO_ON_ERR_EN
    localparam bit ZERO_ON_ERR = 1'b1;
`else
    localparam bit ZERO_ON_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();
    tdm_demux #(.WIDTH(WIDTH), .NCH(NCH), .CW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Frame model: channel contents, lock flag and next expected slot.
    logic [WIDTH-1:0] ch [NCH];
    bit               m_lock = 1'b0;
    int               m_slot = 0;
    logic [NCH-1:0]   m_vld  = '0;
    bit               m_fd   = 1'b0;
    bit               m_err  = 1'b0;
    bit               started = 1'b0;

    // Literal pins set by the stimulus for the cycle just after an edge.
    logic [NCH*WIDTH-1:0] p_y;
    logic [NCH-1:0]       p_v;
    logic                 p_fd, p_err, p_lk;
    logic [4:0]           p_mask = '0;

    function automatic logic [NCH*WIDTH-1:0] model_y();
        logic [NCH*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k*WIDTH +: WIDTH] = ch[k];
        return r;
    endfunction

    always @(posedge clk) begin
        m_vld = '0;
        m_fd  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            for (int k = 0; k < NCH; k++) ch[k] = '0;
            m_lock = 1'b0;
            m_slot = 0;
        end else if (bus.in_valid) begin
            if (!m_lock) begin
                if (bus.in_sync) begin
                    ch[0] = bus.x; m_vld = 1; m_slot = 1; m_lock = 1'b1;
                end
            end else if (bus.in_sync) begin
                if (m_slot != 0) begin
                    m_err = 1'b1;
                    if (ZERO_ON_ERR) for (int k = 0; k < NCH; k++) ch[k] = '0;
                end
                ch[0] = bus.x; m_vld = 1; m_slot = 1;
            end else if (m_slot == 0) begin
                m_err = 1'b1;
                m_lock = 1'b0;
                if (ZERO_ON_ERR) for (int k = 0; k < NCH; k++) ch[k] = '0;
            end else begin
                ch[m_slot] = bus.x;
                m_vld = NCH'(1) << m_slot;
                if (m_slot == NCH-1) m_fd = 1'b1;
                m_slot = (m_slot + 1) % NCH;
            end
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("y",          64'(bus.y),          64'(model_y()));
            chk("y_valid",    64'(bus.y_valid),    64'(m_vld));
            chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
            chk("sync_err",   64'(bus.sync_err),   64'(m_err));
            chk("locked",     64'(bus.locked),     64'(m_lock));
            if (p_mask[0]) chk("pin_y",   64'(bus.y),          64'(p_y));
            if (p_mask[1]) chk("pin_vld", 64'(bus.y_valid),    64'(p_v));
            if (p_mask[2]) chk("pin_fd",  64'(bus.frame_done), 64'(p_fd));
            if (p_mask[3]) chk("pin_err", 64'(bus.sync_err),   64'(p_err));
            if (p_mask[4]) chk("pin_lk",  64'(bus.locked),     64'(p_lk));
        end
    end

    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.x        = d;
        @(posedge clk);
        #1;
        p_mask = '0;
    endtask

    task automatic pin(input logic [4:0] m, input logic [NCH*WIDTH-1:0] y,
                       input logic [NCH-1:0] v, input logic fd, input logic err, input logic lk);
        p_mask = m; p_y = y; p_v = v; p_fd = fd; p_err = err; p_lk = lk;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.x        = '0;
        rst = 1'b1;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        pin(5'b11111, 32'h0, 4'h0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00);
        pin(5'b11111, 32'h0, 4'h0, 0, 0, 0);

        // Unsynced words in HUNT are dropped.
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        pin(5'b10011, 32'h0, 4'h0, 0, 0, 0);

        // Clean back-to-back frame.
        step(1, 1, 8'hA0); pin(5'b10010, 32'h0, 4'h1, 0, 0, 1);
        step(1, 0, 8'hA1); pin(5'b00010, 32'h0, 4'h2, 0, 0, 0);
        step(1, 0, 8'hA2); pin(5'b00110, 32'h0, 4'h4, 0, 0, 0);
        step(1, 0, 8'hA3); pin(5'b10111, 32'hA3A2A1A0, 4'h8, 1, 0, 1);

        // Same shape with 3-cycle gaps.
        for (int w = 0; w < NCH; w++) begin
            step(1, w == 0, 8'hE0 + 8'(w));
            pin(5'b00010, 32'h0, NCH'(1) << w, 0, 0, 0);
            for (int g = 0; g < 3; g++) step(0, 0, 8'h00);
        end
        pin(5'b10011, 32'hE3E2E1E0, 4'h0, 0, 0, 1);

        // Early sync.
        step(1, 1, 8'hB0);
        step(1, 0, 8'hB1);
        step(1, 1, 8'hC0);
        pin(5'b11111, ZERO_ON_ERR ? 32'h000000C0 : 32'hE3E2B1C0, 4'h1, 0, 1, 1);

        // Finish frame, then a missing sync.
        step(1, 0, 8'hC1);
        step(1, 0, 8'hC2);
        step(1, 0, 8'hC3); pin(5'b00101, 32'hC3C2C1C0, 4'h0, 1, 0, 0);
        step(1, 0, 8'hD0);
        pin(5'b01111, ZERO_ON_ERR ? 32'h0 : 32'hC3C2C1C0, 4'h0, 0, 1, 0);
        step(0, 0, 8'h00); pin(5'b11000, 32'h0, 4'h0, 0, 0, 0);

        // Mid-frame reset.
        step(1, 1, 8'hF0);
        step(1, 0, 8'hF1);
        rst = 1'b1;
        step(0, 0, 8'h00);
        pin(5'b11111, 32'h0, 4'h0, 0, 0, 0);
        rst = 1'b0;
        step(1, 1, 8'h5A); pin(5'b10011, 32'h0000005A, 4'h1, 0, 0, 1);

        // Random traffic with occasional resets and ignored idle syncs.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, 8'($urandom));
        end
        rst = 1'b0;
        step(0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive-side counterpart of the lab's 2:1/N:1 mux datapath.
- Accepts one serial word stream, with one word per channel slot and a frame-sync marker on slot 0.
- Routes each word to its per-channel holding register and strobes a per-channel valid.
- Tracks frame alignment and flags sync errors. Sits between a TDM mux/serialiser and per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel sample.
- NCH, 4, number of channels/slots per frame; legal range 2..16.
- CW, 4, slot counter width; must satisfy 2**CW >= NCH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a word is presented on x this cycle.
- in_sync  input  1  qualifies x as slot 0 (frame start); ignored when in_valid=0.
- x  input  WIDTH  incoming multiplexed sample.
- y  output  NCH*WIDTH  channel registers; channel k occupies y[k*WIDTH +: WIDTH].
- y_valid  output  NCH  one-cycle pulse; bit k high in the cycle after channel k is written.
- frame_done  output  1  one-cycle pulse in the cycle after channel NCH-1 is written.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high while in LOCKED state.

Behaviour:
- Reset (rst=1 at clk edge), which overrides every other input:
  - y=0, y_valid=0, frame_done=0, sync_err=0, locked=0.
  - Slot counter=0; state=HUNT.
  - Reset mid-frame discards the partial frame. Channel registers already written are cleared to 0.
- State HUNT:
  - in_valid & !in_sync: word dropped, no outputs change.
  - in_valid & in_sync: write ch0 and pulse y_valid[0] next cycle. Set slot=1 and go to LOCKED; locked goes high the next cycle.
- State LOCKED, with in_valid=1:
  - !in_sync & slot!=0: write ch[slot] and pulse y_valid[slot]. slot increments, or wraps to 0 after NCH-1. Writing NCH-1 also pulses frame_done.
  - in_sync & slot==0: normal frame start. Write ch0, slot=1.
  - in_sync & slot!=0 (early sync): pulse sync_err and treat the word as a new frame start. Write ch0, slot=1, stay LOCKED. No frame_done for the truncated frame.
  - !in_sync & slot==0 (missing sync): pulse sync_err, drop the word, go to HUNT, slot=0.
- State LOCKED, with in_valid=0: hold; slot and registers unchanged. Gaps between words of any length are legal.
- Latency: a word accepted at edge n appears on y and its strobe at edge n (registered). It is visible to consumers in the following cycle.
- Channel registers hold their value until rewritten. Only the addressed channel changes.
- y_valid is one-hot or zero. frame_done coincides with y_valid[NCH-1].
- sync_err and a y_valid[0] pulse can coincide (early-sync case).
- No backpressure: the block always accepts.

Optional Feature:
- Macro: TDM_DEMUX_ZERO_ON_ERR_EN.
- Defined: on any sync_err event, all channel registers except the one written in that same cycle are cleared to 0 in that edge. Consumers therefore never see stale data mixed across frames.
- Undefined: sync_err does not alter channel registers; stale values persist.

Test Plan (NCH=4, WIDTH=8):
- Reset, then idle 5 cycles -> y=0, all strobes 0, locked=0.
- In HUNT, feed words 0x11, 0x22 without sync -> dropped; y stays 0, locked=0.
- Feed a clean frame: sync+0xA0, then 0xA1, 0xA2, 0xA3 back-to-back:
  - y_valid pulses 0001, 0010, 0100, 1000 on successive cycles.
  - frame_done pulses with the last one; y=0xA3A2A1A0; locked=1.
- Same frame with in_valid gaps of 3 idle cycles between words -> identical final y and pulses, each delayed accordingly.
- Early sync: frame 0xB0, 0xB1, then sync+0xC0:
  - sync_err=1 with y_valid[0]; ch0=0xC0; no frame_done.
  - Without the macro, ch1=0xB1; with TDM_DEMUX_ZERO_ON_ERR_EN, ch1=0.
- Missing sync and mid-frame reset:
  - Missing sync: after a full frame, feed 0xD0 without sync -> sync_err=1, word dropped, locked=0 next cycle.
  - Mid-frame reset: assert rst after 2 words of a frame -> y=0, locked=0, next sync word lands in ch0.
